p2s_serializer: RTL and testbench

Parametrised parallel-to-serial converter. It accepts a WIDTH-bit word over a valid/ready handshake and buffers one word ahead. It shifts the word out one bit per clk, MSB-first or LSB-first, selected per word. It sits between the ADC/parallel capture logic and the serial link drivers, and qualifies the bit stream with an enable plus a per-word done pulse.

---
 rtl/p2s_serializer.sv | 145 ++++++++++++++
 tb/tb_p2s_serializer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_serializer.sv
// p2s_serializer: parallel-to-serial converter with a one-word holding buffer.
// A word is taken over a valid/ready handshake and later shifted out one bit
// per clock, MSB-first or LSB-first as chosen when the word is accepted.
// dout_en qualifies the serial stream, and done pulses once after each word.
// GAP adds idle cycles after each word's END cycle.
// Optional build macro P2S_PARITY_EN appends an even-parity bit to each word.
module p2s_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             msb_first,
  output logic             dout_bit,
  output logic             dout_en,
  output logic             done,
  output logic             busy
);

`ifdef P2S_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_END,
    ST_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold_buf;
  logic             hold_mode;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;
  logic             mode;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             accept;
  logic             load;
  logic             shift_bit;
`ifdef P2S_PARITY_EN
  logic             parity;
`endif

  // Ready depends only on the buffer flag and reset, so it never loops back from din_valid.
  assign din_ready = !hold_full && !rst;
  assign accept    = din_valid && din_ready;
  assign busy      = (state != ST_IDLE) || hold_full;

  // Move the held word into the shifter in IDLE, or straight from END when no gap is configured.
  assign load = hold_full && ((state == ST_IDLE) || ((state == ST_END) && (GAP == 0)));

  // Pick the next serial bit: the used end of the shifter, or the parity bit last.
  always_comb begin
    shift_bit = mode ? shreg[WIDTH-1] : shreg[0];
`ifdef P2S_PARITY_EN
    if (bit_cnt == LAST_BIT) shift_bit = parity;
`endif
  end

  // Capture the incoming word and its bit order into the holding buffer.
  // NOTE: the buffer data carries no reset; hold_full says whether it holds a word.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_buf  <= din;
      hold_mode <= msb_first;
    end
  end

  // Control FSM, shifter and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      shreg     <= '0;
      mode      <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      dout_bit  <= 1'b0;
      dout_en   <= 1'b0;
      done      <= 1'b0;
`ifdef P2S_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) hold_full <= 1'b1;

      case (state)
        ST_IDLE: begin
          dout_en  <= 1'b0;
          dout_bit <= 1'b0;
        end
        ST_SHIFT: begin
          dout_en  <= 1'b1;
          dout_bit <= shift_bit;
          shreg    <= mode ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state <= ST_END;
        end
        ST_END: begin
          dout_en  <= 1'b0;
          dout_bit <= 1'b0;
          done     <= 1'b1;
          if (GAP > 0) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_GAP: begin
          dout_en  <= 1'b0;
          dout_bit <= 1'b0;
          gap_cnt  <= gap_cnt + 1'b1;
          if (gap_cnt == LAST_GAP) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // NOTE: placed after the case so its state update wins over END's IDLE/GAP choice.
      if (load) begin
        shreg     <= hold_buf;
        mode      <= hold_mode;
        hold_full <= 1'b0;
        bit_cnt   <= '0;
        state     <= ST_SHIFT;
`ifdef P2S_PARITY_EN
        parity    <= ^hold_buf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
// Testbench for p2s_serializer: two instances (GAP=0 and GAP=3) share one
// scoreboard. Accepted words push their expected bit stream and done cycle,
// and a negedge monitor pops and compares on every done pulse.
module tb_p2s_serializer;

  localparam int W = 8;
`ifdef P2S_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         msb_first;
  logic [1:0]   din_valid;
  logic [1:0]   din_ready;
  logic [1:0]   dout_bit;
  logic [1:0]   dout_en;
  logic [1:0]   done;
  logic [1:0]   busy;

  p2s_serializer #(.WIDTH(W), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .msb_first(msb_first), .dout_bit(dout_bit[0]), .dout_en(dout_en[0]), .done(done[0]),
    .busy(busy[0])
  );

  p2s_serializer #(.WIDTH(W), .GAP(3)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .msb_first(msb_first), .dout_bit(dout_bit[1]), .dout_en(dout_en[1]), .done(done[1]),
    .busy(busy[1])
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read at negedges it names the edge just taken.
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-computed vectors: serial order written first-bit-leftmost, plus even parity.
  typedef struct {
    logic [W-1:0] d;
    logic         m;
    logic [W-1:0] ser;
    logic         par;
  } vec_t;

  vec_t vt [8] = '{
    '{8'hA5, 1'b1, 8'b10100101, 1'b0},
    '{8'h1D, 1'b0, 8'b10111000, 1'b0},
    '{8'h01, 1'b1, 8'b00000001, 1'b1},
    '{8'h3C, 1'b1, 8'b00111100, 1'b0},
    '{8'h80, 1'b0, 8'b00000001, 1'b1},
    '{8'h6B, 1'b1, 8'b01101011, 1'b1},
    '{8'h6B, 1'b0, 8'b11010110, 1'b1},
    '{8'hF0, 1'b0, 8'b00001111, 1'b0}
  };

  typedef struct {
    int           inst;
    logic [W:0]   bits;
    longint       done_cyc;
  } exp_t;

  exp_t   sb[$];
  longint last_done [2];

  // Drive a word from a negedge; returns at the negedge after its accept edge
  // with din_valid still high, so consecutive calls present words back-to-back.
  task automatic send(input int i, input int v, output longint acc_cyc);
    exp_t   e;
    longint g, l;
    din          = vt[v].d;
    msb_first    = vt[v].m;
    din_valid[i] = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (din_ready[i] === 1'b1) begin
        acc_cyc = cyc + 1;
        g = (i == 0) ? 0 : 3;
        if (g == 0 && acc_cyc < last_done[i]) l = last_done[i];
        else l = (acc_cyc + 1 > last_done[i] + g + 1) ? acc_cyc + 1 : last_done[i] + g + 1;
        e.inst = i;
`ifdef P2S_PARITY_EN
        e.bits = {vt[v].ser, vt[v].par};
`else
        e.bits = {1'b0, vt[v].ser};
`endif
        e.done_cyc   = l + 1 + NB;
        last_done[i] = e.done_cyc;
        sb.push_back(e);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", 64'd0, 64'd1);
    acc_cyc = -1;
  endtask

  task automatic idle(input int n);
    din_valid = 2'b00;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: assemble each instance's serial stream and compare on done.
  logic [W:0] acc [2];
  int         cnt [2];
  longint     first [2];
  exp_t       mon_e;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        acc[i] = '0;
        cnt[i] = 0;
      end else begin
        if (dout_en[i]) begin
          if (cnt[i] == 0) first[i] = cyc;
          acc[i] = {acc[i][W-1:0], dout_bit[i]};
          cnt[i]++;
        end else if (dout_bit[i] !== 1'b0) begin
          check("bit_zero_when_disabled", 64'(dout_bit[i]), 64'd0);
        end
        if (done[i]) begin
          if (sb.size() == 0) begin
            check("done_unexpected", 64'd1, 64'd0);
          end else begin
            mon_e = sb.pop_front();
            check("word_inst", 64'(i), 64'(mon_e.inst));
            check("word_bits", 64'(acc[i]), 64'(mon_e.bits));
            check("word_nbits", 64'(cnt[i]), 64'(NB));
            check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
            check("first_bit_cycle", 64'(first[i]), 64'(mon_e.done_cyc - NB));
          end
          acc[i] = '0;
          cnt[i] = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint a0, a1;
    int     seen;
    rst          = 1'b1;
    din_valid    = 2'b00;
    din          = '0;
    msb_first    = 1'b0;
    last_done[0] = -1000;
    last_done[1] = -1000;
    repeat (3) @(negedge clk);

    // Reset state, with rst still asserted.
    check("rst_ready", 64'(din_ready), 64'd0);
    check("rst_dout_en", 64'(dout_en), 64'd0);
    check("rst_dout_bit", 64'(dout_bit), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(din_ready), 64'b11);

    // Single word A5 MSB-first; ready drops for one cycle only.
    send(0, 0, a0);
    din_valid = 2'b00;
    check("ready_low_after_accept", 64'(din_ready[0]), 64'd0);
    check("busy_after_accept", 64'(busy[0]), 64'd1);
    @(negedge clk);
    check("ready_high_after_load", 64'(din_ready[0]), 64'd1);
    idle(15);
    check("busy_idle", 64'(busy[0]), 64'd0);

    // 1D LSB-first with msb_first toggling mid-word.
    send(0, 1, a0);
    din_valid = 2'b00;
    repeat (9) begin
      msb_first = ~msb_first;
      @(negedge clk);
    end
    idle(6);

    // Back-to-back A5 then 1D with valid held.
    send(0, 0, a0);
    send(0, 1, a1);
    din_valid = 2'b00;
    check("b2b_accept_edge", 64'(a1), 64'(a0 + 2));
    check("b2b_ready_low", 64'(din_ready[0]), 64'd0);
    while (cyc < a0 + 9) @(negedge clk);
    check("b2b_ready_low_k9", 64'(din_ready[0]), 64'd0);
    @(negedge clk);
    check("b2b_ready_high_k10", 64'(din_ready[0]), 64'd1);
    idle(20);

    // Remaining vectors streamed back-to-back.
    for (int v = 2; v < 8; v++) send(0, v, a0);
    idle(30);

    // GAP=3 instance with two queued words, then a lone word.
    send(1, 3, a0);
    send(1, 4, a1);
    idle(40);
    send(1, 5, a0);
    idle(25);

    // Reset mid-word at edge k+5 with a second word buffered.
    send(0, 5, a0);
    send(0, 6, a1);
    din_valid = 2'b00;
    while (cyc < a0 + 4) @(negedge clk);
    check("pre_rst_buffer_full", 64'(din_ready[0]), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_dout_en", 64'(dout_en[0]), 64'd0);
    check("abort_dout_bit", 64'(dout_bit[0]), 64'd0);
    check("abort_done", 64'(done[0]), 64'd0);
    check("abort_busy", 64'(busy[0]), 64'd0);
    check("abort_ready_in_rst", 64'(din_ready[0]), 64'd0);
    sb.delete();
    last_done[0] = -1000;
    last_done[1] = -1000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_abort", 64'(din_ready[0]), 64'd1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (dout_en[0] || done[0]) seen++;
    end
    check("aborted_words_silent", 64'(seen), 64'd0);

    // Recovery after the abort.
    send(0, 0, a0);
    idle(20);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
